// File: rtl/cordic_ln_pkg.sv
// cordic_ln_pkg: shared CORDIC ln datapath defaults and loop-control state encoding.
package cordic_ln_pkg;
    localparam int W_DEF     = 32;
    localparam int ITER_DEF  = 16;
    localparam int CNT_W_DEF = 5;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        HOLD  = 2'd2
    } state_t;
endpackage

// File: rtl/demux_ac_capture_if.sv
// demux_ac_capture_if: stage-result handshake between the rotation stage, feedback selector and result consumer.
interface demux_ac_capture_if #(
    parameter int W     = 32,
    parameter int CNT_W = 5
);
    logic             start;
    logic             in_valid;
    logic [W-1:0]     D;
    logic             ack;
    logic [W-1:0]     S0;
    logic             S0_valid;
    logic [W-1:0]     S1;
    logic             S1_valid;
    logic             busy;
    logic [CNT_W-1:0] iter;
    logic             drop_err;
    modport master (
        output start, in_valid, D, ack,
        input  S0, S0_valid, S1, S1_valid, busy, iter, drop_err
    );
    modport slave (
        input  start, in_valid, D, ack,
        output S0, S0_valid, S1, S1_valid, busy, iter, drop_err
    );
endinterface

// File: rtl/demux_ac_capture_iter_counter.sv
// iter_counter: clearable iteration counter flagging the final CORDIC iteration.
module iter_counter #(
    parameter int ITER  = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);
    assign tc = count == CNT_W'(ITER - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else count <= clr ? '0 : en ? count + 1'b1 : count;
endmodule

// File: rtl/demux_ac_capture.sv
// demux_ac_capture: steers the first ITER-1 stage results to feedback (S0) and holds the last one on S1 until ack.
module demux_ac_capture
    import cordic_ln_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int ITER  = ITER_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic               clk,
    input logic               rst_n,
    demux_ac_capture_if.slave bus
);
    state_t state, nxt;
    logic   tc, beat;
    assign beat     = state == ROUTE && bus.in_valid;
    assign bus.busy = state == ROUTE || state == HOLD;
    // Counter restarts on every entry into ROUTE, whether from IDLE or a back-to-back ack+start.
    iter_counter #(.ITER(ITER), .CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (nxt == ROUTE && state != ROUTE),
        .en    (beat && !tc),
        .count (bus.iter),
        .tc    (tc)
    );
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.start ? ROUTE : IDLE;
            ROUTE:   nxt = (beat && tc) ? HOLD : ROUTE;
            HOLD:    nxt = bus.ack ? (bus.start ? ROUTE : IDLE) : HOLD;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus.S0       <= '0;
            bus.S1       <= '0;
            bus.S0_valid <= 1'b0;
            bus.S1_valid <= 1'b0;
            bus.drop_err <= 1'b0;
        end else begin
            bus.S0_valid <= beat && !tc;
            if (beat && !tc) bus.S0 <= bus.D;
            if (beat && tc) begin
                bus.S1       <= bus.D;
                bus.S1_valid <= 1'b1;
            end else if (state == HOLD && bus.ack) bus.S1_valid <= 1'b0;
            if (bus.in_valid && state != ROUTE) bus.drop_err <= 1'b1;
        end
endmodule

// File: tb/tb_demux_ac_capture.sv
// tb_demux_ac_capture: directed vectors with a per-cycle operation-level model and literal spot checks.
module tb_demux_ac_capture;
    localparam int W = 32, ITER = 4, CNT_W = 5;
    logic clk = 1'b0, rst_n = 1'b0;
    int total = 0, bad = 0;
    demux_ac_capture_if #(.W(W), .CNT_W(CNT_W)) bus ();
    demux_ac_capture #(.W(W), .ITER(ITER), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    // Model: an operation is "open" after start, collects ITER beats, then waits for ack.
    int          phase;
    int          beats;
    logic [W-1:0] m_s0, m_s1;
    logic         m_s0v, m_s1v, m_drop;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            phase <= 0; beats <= 0; m_s0 <= '0; m_s1 <= '0;
            m_s0v <= 1'b0; m_s1v <= 1'b0; m_drop <= 1'b0;
        end else begin
            m_s0v <= 1'b0;
            if (bus.in_valid && phase != 1) m_drop <= 1'b1;
            if (phase == 0 && bus.start) begin
                phase <= 1; beats <= 0;
            end else if (phase == 1 && bus.in_valid) begin
                if (beats + 1 < ITER) begin
                    m_s0 <= bus.D; m_s0v <= 1'b1; beats <= beats + 1;
                end else begin
                    m_s1 <= bus.D; m_s1v <= 1'b1; phase <= 2;
                end
            end else if (phase == 2 && bus.ack) begin
                m_s1v <= 1'b0;
                phase <= bus.start ? 1 : 0;
                if (bus.start) beats <= 0;
            end
        end

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("S0", 64'(bus.S0), 64'(m_s0));
        chk("S0_valid", 64'(bus.S0_valid), 64'(m_s0v));
        chk("S1", 64'(bus.S1), 64'(m_s1));
        chk("S1_valid", 64'(bus.S1_valid), 64'(m_s1v));
        chk("busy", 64'(bus.busy), 64'(phase != 0));
        chk("iter", 64'(bus.iter), 64'(beats));
        chk("drop_err", 64'(bus.drop_err), 64'(m_drop));
        chk("no_overlap", 64'(bus.S0_valid && bus.S1_valid), 64'(0));
    end

    task automatic step(input logic st, input logic iv, input logic [W-1:0] d, input logic ak);
        bus.start = st; bus.in_valid = iv; bus.D = d; bus.ack = ak;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.ack = 1'b0;
    endtask

    logic [W-1:0] vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    initial begin
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.D = '0; bus.ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_S1", 64'(bus.S1), 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'h0);
        rst_n = 1'b1;
        step(1, 0, 0, 0);
        chk("start_busy", 64'(bus.busy), 64'h1);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, vals[i], 0);
            if (i < 3) begin
                chk("s0_val", 64'(bus.S0), 64'(vals[i]));
                chk("s0_pulse", 64'(bus.S0_valid), 64'h1);
            end
        end
        chk("s1_val", 64'(bus.S1), 64'h44);
        chk("s1_iter", 64'(bus.iter), 64'h3);
        repeat (5) step(0, 0, 0, 0);
        chk("s1_hold", 64'(bus.S1), 64'h44);
        chk("s1v_hold", 64'(bus.S1_valid), 64'h1);
        step(1, 0, 0, 1);
        chk("b2b_busy", 64'(bus.busy), 64'h1);
        chk("b2b_s1v", 64'(bus.S1_valid), 64'h0);
        for (int i = 0; i < 4; i++) step(0, 1, 32'hA0 + 32'(i), 0);
        chk("b2b_s1", 64'(bus.S1), 64'hA3);
        step(0, 0, 0, 1);
        chk("ack_idle", 64'(bus.busy), 64'h0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, vals[i], 0);
            step(i == 1, 0, 0, 0);
            if (i == 1) chk("mid_start_iter", 64'(bus.iter), 64'h2);
            if (i < 3) step(0, 0, 0, 0);
        end
        chk("gap_s1", 64'(bus.S1), 64'h44);
        step(0, 1, 32'hDEAD, 0);
        chk("hold_drop", 64'(bus.drop_err), 64'h1);
        chk("hold_s1", 64'(bus.S1), 64'h44);
        step(0, 0, 0, 1);
        step(0, 1, 32'hDEAD, 0);
        chk("idle_drop", 64'(bus.drop_err), 64'h1);
        step(1, 0, 0, 0);
        step(0, 1, 32'h11, 0);
        step(0, 1, 32'h22, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_S0", 64'(bus.S0), 64'h0);
        chk("arst_S1", 64'(bus.S1), 64'h0);
        chk("arst_iter", 64'(bus.iter), 64'h0);
        chk("arst_drop", 64'(bus.drop_err), 64'h0);
        chk("arst_busy", 64'(bus.busy), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 32'h55 + 32'(i), 0);
        chk("fresh_s1", 64'(bus.S1), 64'h58);
        chk("fresh_s1v", 64'(bus.S1_valid), 64'h1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/demux_ac_capture.md
# demux_ac_capture

Registered 1-to-2 demultiplexer with iteration sequencing for the CORDIC natural-logarithm datapath: the counterpart of the 2:1 input/feedback selector. It receives one W-bit CORDIC stage result per valid beat. It steers the first ITER-1 results to the feedback port (S0) and the final result to the output port (S1). The final result is held until the consumer acknowledges it. It sits at the tail of the iteration loop, between the rotation stage and the result register / feedback selector.

## Interface
- W, 32, data width (two's complement fixed point, passed through unmodified)
- ITER, 16, CORDIC iterations per operation; legal range 2..31
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > ITER
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- start  in  1  one-cycle pulse, begins an operation
- in_valid  in  1  D carries a stage result this cycle
- D  in  W  stage result
- ack  in  1  consumer has taken S1
- S0  out  W  feedback value (registered)
- S0_valid  out  1  one-cycle pulse, S0 updated
- S1  out  W  final result (registered, held)
- S1_valid  out  1  level, final result available until ack
- busy  out  1  high in ROUTE or HOLD
- iter  out  CNT_W  current iteration index
- drop_err  out  1  sticky; a beat arrived when not in ROUTE; cleared only by reset

## Operation
- States: IDLE, ROUTE, HOLD; encoding 2 bits, IDLE=0, ROUTE=1, HOLD=2; 3 is unreachable and recovers to IDLE.
- IDLE:
  - start -> ROUTE, iter<=0.
  - in_valid -> drop_err<=1, no routing.
- ROUTE, in_valid with iter<ITER-1:
  - S0<=D, S0_valid<=1 for one cycle, iter<=iter+1.
- ROUTE, in_valid with iter==ITER-1:
  - S1<=D, S1_valid<=1, -> HOLD; iter stays at ITER-1.
- ROUTE, no in_valid: all registers hold.
- start while in ROUTE: ignored, no restart. The current operation always completes.
- HOLD:
  - S1 and S1_valid held until ack.
  - ack -> IDLE, S1_valid<=0; S1 value retained.
  - in_valid -> drop_err<=1; S1 is not overwritten.
  - ack and start in the same cycle -> ROUTE directly, iter<=0, S1_valid<=0.
- ack outside HOLD: no effect.
- S0 retains its last value when not written. S1 changes only on the final beat.
- No arithmetic on data; iter is unsigned and never wraps, because it saturates at ITER-1 by construction.
- Reset (any cycle, including mid-operation):
  - state=IDLE, iter=0.
  - S0=0, S1=0, S0_valid=0, S1_valid=0, busy=0, drop_err=0.
  - A partial operation is discarded.

## Timing
- All outputs are registered; input to output latency is 1 cycle.
- busy rises the cycle after start and falls the cycle after ack.
- Minimum operation length: start, then ITER beats on consecutive cycles.
  - S1_valid rises ITER+1 cycles after start.
- Back-to-back operations: ack+start in one cycle, with no idle bubble.
- S0_valid never coincides with S1_valid.

## Structure
- Shared package cordic_ln_pkg holds the state localparams and the default W/ITER/CNT_W values, also used by the loop controller.
- One sub-module, iter_counter: clear/enable/terminal-count counter of width CNT_W, with tc = (count==ITER-1).
- Top level contains the FSM and the output registers.

## Test plan
- Reset with ITER=4, then start and beats D=0x11,0x22,0x33,0x44 on consecutive cycles:
  - S0 pulses with 0x11,0x22,0x33.
  - S1=0x44, S1_valid=1, iter=3; S1 holds across 5 cycles without ack.
- In HOLD, ack with start in the same cycle, then beats 0xA0..0xA3:
  - state goes to ROUTE with no bubble, S1_valid drops, and the next S1 is 0xA3.
- Beats with gaps (in_valid every third cycle):
  - identical S0/S1 sequence; all outputs are stable between beats.
- in_valid=1 with D=0xDEAD in IDLE, then in HOLD:
  - drop_err=1 and stays set; S1 is unchanged.
  - A start pulse in the middle of ROUTE does not reset iter.
- rst_n asserted asynchronously after the 2nd beat (mid-cycle):
  - all outputs go to 0 immediately; after release, a fresh 4-beat operation completes normally.
